// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter that shares one synchronous-read data
//            memory port between NUM_CH cores. One request is granted per
//            cycle (combinational grant); the load data or store acknowledge
//            returns to the requesting core one cycle later.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req_valid/we/addr/wdata  - per-channel requests (flattened buses)
//            req_lock                 - per-channel lock (DMARB_LOCK_EN only)
//            req_ready                - one-hot grant (or zero)
//            rsp_valid, rsp_rdata     - one-hot response strobe, load data
//            mem_en/we/addr/wdata     - memory request port
//            mem_rdata                - memory read data (one cycle latency)
// Options  : define DMARB_LOCK_EN to add channel locking for atomic
//            read-modify-write sequences.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
`ifdef DMARB_LOCK_EN
  input  logic [NUM_CH-1:0]        req_lock,
`endif
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int C_PTR_W = $clog2(NUM_CH);

  // Registered state
  logic [C_PTR_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [NUM_CH-1:0]  rsp_ch_q,    rsp_ch_d;
  logic               rsp_is_rd_q, rsp_is_rd_d;
`ifdef DMARB_LOCK_EN
  logic               locked_q,    locked_d;
  logic [C_PTR_W-1:0] locked_ch_q, locked_ch_d;
`endif

  // Combinational arbitration signals
  logic [ADDR_W-1:0]  w_addr_arr  [NUM_CH];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_CH];
  logic [NUM_CH-1:0]  w_elig;
  logic [C_PTR_W:0]   w_sum;
  logic [C_PTR_W-1:0] w_cand;
  logic [C_PTR_W-1:0] w_gnt_idx;
  logic               w_found;
  logic [NUM_CH-1:0]  w_grant;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // While a channel holds the lock, only that channel is eligible.
  always_comb begin
    w_elig = req_valid;
`ifdef DMARB_LOCK_EN
    if (locked_q) begin
      w_elig = req_valid & (NUM_CH'(1) << locked_ch_q);
    end
`endif
  end

  // Scan from rr_ptr upward, wrapping modulo NUM_CH; first eligible wins.
  always_comb begin
    w_sum     = '0;
    w_cand    = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = {1'b0, rr_ptr_q} + (C_PTR_W+1)'(k);
      if (w_sum >= (C_PTR_W+1)'(NUM_CH)) begin
        w_sum = w_sum - (C_PTR_W+1)'(NUM_CH);
      end
      w_cand = w_sum[C_PTR_W-1:0];
      if (!w_found && w_elig[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    // Reset masks every grant so nothing reaches memory during reset.
    if (rst) begin
      w_found = 1'b0;
    end
    w_grant = w_found ? (NUM_CH'(1) << w_gnt_idx) : '0;
  end

  // Memory port and request-side outputs
  always_comb begin
    req_ready = w_grant;
    mem_en    = w_found;
    mem_we    = w_found & req_we[w_gnt_idx];
    mem_addr  = w_found ? w_addr_arr[w_gnt_idx]  : '0;
    mem_wdata = w_found ? w_wdata_arr[w_gnt_idx] : '0;
  end

  // Next-state computation
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_ch_d    = w_grant;
    rsp_is_rd_d = w_found & ~req_we[w_gnt_idx];
`ifdef DMARB_LOCK_EN
    locked_d    = locked_q;
    locked_ch_d = locked_ch_q;
    if (w_found) begin
      if (locked_q) begin
        // Only the owner can be granted here; lock=0 releases it.
        if (!req_lock[w_gnt_idx]) begin
          locked_d = 1'b0;
        end
      end else if (req_lock[w_gnt_idx]) begin
        locked_d    = 1'b1;
        locked_ch_d = w_gnt_idx;
      end
    end
    // The pointer stays frozen for as long as the lock is held.
    if (w_found && !locked_d) begin
      rr_ptr_d = (w_gnt_idx == C_PTR_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
    end
`else
    if (w_found) begin
      rr_ptr_d = (w_gnt_idx == C_PTR_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_ch_q    <= '0;
      rsp_is_rd_q <= 1'b0;
`ifdef DMARB_LOCK_EN
      locked_q    <= 1'b0;
      locked_ch_q <= '0;
`endif
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_is_rd_q <= rsp_is_rd_d;
`ifdef DMARB_LOCK_EN
      locked_q    <= locked_d;
      locked_ch_q <= locked_ch_d;
`endif
    end
  end

  // Reset in the response cycle discards the pending response.
  always_comb begin
    rsp_valid = rst ? '0 : rsp_ch_q;
    rsp_rdata = ((|rsp_valid) && rsp_is_rd_q) ? mem_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter (NUM_CH = 4). A memory
//            model answers the DUT's memory port; a behavioural model of the
//            arbitration rules predicts every output each cycle, and directed
//            literal expectations pin the key sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
`ifdef DMARB_LOCK_EN
  logic [NUM_CH-1:0]        req_lock;
`endif
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata = '0;

  logic [ADDR_W-1:0] a_addr  [NUM_CH];
  logic [DATA_W-1:0] a_wdata [NUM_CH];

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = a_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = a_wdata[i];
    end
  end

  dmem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ memory model
  // Unwritten locations read back their own address.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] mem_lookup(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return DATA_W'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem_lookup(mem_addr);
    end
  end

  // ------------------------------------------------------ behavioural model
  int                m_ptr     = 0;
  logic [NUM_CH-1:0] m_rsp_ch  = '0;
  logic [DATA_W-1:0] m_rsp_dat = '0;
  bit                m_locked  = 1'b0;
  int                m_lock_ch = 0;
  int                g;
  int                c;
  logic [NUM_CH-1:0] e_rdy;

  always @(negedge clk) begin
    // Predicted grant: first valid (and eligible) channel from m_ptr upward.
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (g < 0 && req_valid[c] && (!m_locked || c == m_lock_ch)) g = c;
      end
    end
    e_rdy = (g >= 0) ? NUM_CH'(1 << g) : '0;

    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("mem_en",    64'(mem_en),    64'(g >= 0));
    chk("mem_we",    64'(mem_we),    (g >= 0) ? 64'(req_we[g])  : 64'(0));
    chk("mem_addr",  64'(mem_addr),  (g >= 0) ? 64'(a_addr[g])  : 64'(0));
    chk("mem_wdata", 64'(mem_wdata), (g >= 0) ? 64'(a_wdata[g]) : 64'(0));
    chk("rsp_valid", 64'(rsp_valid), rst ? 64'(0) : 64'(m_rsp_ch));
    chk("rsp_rdata", 64'(rsp_rdata), rst ? 64'(0) : 64'(m_rsp_dat));

    // Advance the model to what the next cycle must look like.
    if (rst) begin
      m_ptr     = 0;
      m_rsp_ch  = '0;
      m_rsp_dat = '0;
      m_locked  = 1'b0;
      m_lock_ch = 0;
    end else begin
      m_rsp_ch  = e_rdy;
      m_rsp_dat = (g >= 0 && !req_we[g]) ? mem_lookup(a_addr[g]) : '0;
      if (g >= 0) begin
`ifdef DMARB_LOCK_EN
        if (m_locked) begin
          if (!req_lock[g]) m_locked = 1'b0;
        end else if (req_lock[g]) begin
          m_locked  = 1'b1;
          m_lock_ch = g;
        end
`endif
        if (!m_locked) m_ptr = (g + 1) % NUM_CH;
      end
    end
  end

  // ------------------------------------------------------- directed stimulus
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_we    = 4'b0000;
`ifdef DMARB_LOCK_EN
    req_lock  = 4'b0000;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      a_addr[i]  = 32'h100 + 32'(4 * i);
      a_wdata[i] = 32'h0;
    end

    // Reset held two cycles with every channel requesting.
    for (int r = 0; r < 2; r++) begin
      settle();
      chk("lit_rst_ready",  64'(req_ready), 64'h0);
      chk("lit_rst_rspv",   64'(rsp_valid), 64'h0);
      chk("lit_rst_mem_en", 64'(mem_en),    64'h0);
      chk("lit_rst_rdata",  64'(rsp_rdata), 64'h0);
      nxt();
    end
    rst = 1'b0;

    // Round robin, all channels loading continuously.
    settle(); chk("lit_rr0", 64'(req_ready), 64'b0001);
    nxt(); settle(); chk("lit_rr1", 64'(req_ready), 64'b0010);
    chk("lit_rr1_rspv", 64'(rsp_valid), 64'b0001); chk("lit_rr1_rd", 64'(rsp_rdata), 64'h100);
    nxt(); settle(); chk("lit_rr2", 64'(req_ready), 64'b0100);
    chk("lit_rr2_rspv", 64'(rsp_valid), 64'b0010); chk("lit_rr2_rd", 64'(rsp_rdata), 64'h104);
    nxt(); settle(); chk("lit_rr3", 64'(req_ready), 64'b1000);
    chk("lit_rr3_rd", 64'(rsp_rdata), 64'h108);
    nxt(); settle(); chk("lit_rr4", 64'(req_ready), 64'b0001);
    chk("lit_rr4_rspv", 64'(rsp_valid), 64'b1000); chk("lit_rr4_rd", 64'(rsp_rdata), 64'h10C);
    nxt(); req_valid = 4'b0000;
    settle(); chk("lit_idle_ready", 64'(req_ready), 64'h0); chk("lit_idle_mem_en", 64'(mem_en), 64'h0);

    // ch2 store then load of the same address.
    nxt(); req_valid = 4'b0100; req_we = 4'b0100; a_addr[2] = 32'h40; a_wdata[2] = 32'hDEADBEEF;
    settle(); chk("lit_st_ready", 64'(req_ready), 64'b0100);
    chk("lit_st_we", 64'(mem_we), 64'h1); chk("lit_st_addr", 64'(mem_addr), 64'h40);
    nxt(); req_we = 4'b0000;
    settle(); chk("lit_ld_ready", 64'(req_ready), 64'b0100);
    chk("lit_st_rspv", 64'(rsp_valid), 64'b0100); chk("lit_st_rd", 64'(rsp_rdata), 64'h0);
    nxt(); req_valid = 4'b0000;
    settle(); chk("lit_ld_rspv", 64'(rsp_valid), 64'b0100);
    chk("lit_ld_rd", 64'(rsp_rdata), 64'hDEADBEEF);

    // Sparse requests and pointer wrap (pointer brought to 2 via ch1).
    nxt(); req_valid = 4'b0010; settle(); chk("lit_sp_pre", 64'(req_ready), 64'b0010);
    nxt(); req_valid = 4'b1010; settle(); chk("lit_sp_ch3", 64'(req_ready), 64'b1000);
    nxt(); req_valid = 4'b0010; settle(); chk("lit_sp_ch1", 64'(req_ready), 64'b0010);
    nxt(); req_valid = 4'b1111; settle(); chk("lit_sp_ptr2", 64'(req_ready), 64'b0100);

    // Reset while a response is pending.
    nxt(); req_valid = 4'b0010; settle(); chk("lit_mr_gnt", 64'(req_ready), 64'b0010);
    nxt(); req_valid = 4'b0000; rst = 1'b1;
    settle(); chk("lit_mr_rspv", 64'(rsp_valid), 64'h0); chk("lit_mr_rd", 64'(rsp_rdata), 64'h0);
    nxt(); rst = 1'b0; req_valid = 4'b1111;
    settle(); chk("lit_mr_ptr0", 64'(req_ready), 64'b0001);

`ifdef DMARB_LOCK_EN
    // ch0 locks, idles two cycles, then unlocks with a store; ch1 waits.
    nxt(); rst = 1'b1; req_valid = 4'b0000;
    nxt(); rst = 1'b0; req_valid = 4'b0011; req_lock = 4'b0001;
    settle(); chk("lit_lk_gnt0", 64'(req_ready), 64'b0001);
    nxt(); req_valid = 4'b0010; req_lock = 4'b0000;
    settle(); chk("lit_lk_hold1", 64'(req_ready), 64'h0); chk("lit_lk_mem_en1", 64'(mem_en), 64'h0);
    nxt();
    settle(); chk("lit_lk_hold2", 64'(req_ready), 64'h0); chk("lit_lk_mem_en2", 64'(mem_en), 64'h0);
    nxt(); req_valid = 4'b0011; req_we = 4'b0001;
    settle(); chk("lit_lk_unlock", 64'(req_ready), 64'b0001);
    nxt(); req_valid = 4'b0010; req_we = 4'b0000;
    settle(); chk("lit_lk_ch1", 64'(req_ready), 64'b0010);
`endif

    nxt(); req_valid = 4'b0000;
    settle();
    nxt();
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Parametrised N-channel data-memory arbiter for the multicore MIPS tops. It replaces the fixed four-port data-memory wiring with a round-robin shared port. NUM_CH cores issue load/store requests through a valid/ready handshake; one request per cycle goes to a single synchronous-read data memory, and the read data or write acknowledge returns to the originating core one cycle later.

## Interface
- NUM_CH, 4: number of requesting cores; legal range 2–8.
- ADDR_W, 32: byte address width; passes through unchanged.
- DATA_W, 32: data word width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_we  in  NUM_CH  per-channel request type: 1 = store, 0 = load.
- req_addr  in  NUM_CH*ADDR_W  flattened addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  flattened store data, same packing as req_addr.
- req_lock  in  NUM_CH  lock request; present only when DMARB_LOCK_EN is defined.
- req_ready  out  NUM_CH  grant, one-hot or zero; a request is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_CH  one-hot response strobe.
- rsp_rdata  out  DATA_W  load data, valid when any rsp_valid bit is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous read data; valid the cycle after mem_en with mem_we = 0.

## Operation
- State:
  - rr_ptr: highest-priority channel, log2(NUM_CH) bits.
  - rsp_ch: registered grant, NUM_CH bits.
  - rsp_is_rd: 1 bit.
  - Lock state when DMARB_LOCK_EN is defined.
- Arbitration is combinational each cycle:
  - Scan channels starting at rr_ptr, wrapping modulo NUM_CH.
  - The first channel with req_valid = 1 receives req_ready.
  - If no channel is valid, req_ready = 0 and mem_en = 0.
- Memory port:
  - mem_en = 1 whenever any channel is granted.
  - mem_we, mem_addr and mem_wdata come from the granted channel.
  - When no channel is granted, mem_we = 0 and the address/data outputs hold 0.
- Pointer update: after a grant to channel g, rr_ptr ← (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Response, one cycle after the grant:
  - rsp_valid[g] = 1 for both loads and stores; a store's response is its write acknowledge.
  - rsp_rdata = mem_rdata for loads and 0 for stores.
  - rsp_rdata = 0 whenever rsp_valid is all-zero.
- Core stall rule: a core must hold req_valid, req_we, req_addr and req_wdata stable until its req_ready is sampled high. The arbiter does not check this.
- Reset values:
  - req_ready = 0 and rsp_valid = 0 (all bits).
  - rsp_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - rr_ptr = 0; lock state cleared.
  - While rst = 1, req_ready is forced to 0 regardless of req_valid.

## Timing
- Request path: zero-cycle grant (combinational req_valid → req_ready → mem_*).
- Response latency: exactly 1 cycle after acceptance.
- Throughput: 1 access per cycle aggregate. A lone requester gets back-to-back grants every cycle.
- Fairness: with all NUM_CH channels continuously valid, each channel is granted exactly once every NUM_CH cycles.
- Overlap: the response for the cycle-T grant and a new grant in T+1 occur in the same cycle. The response never blocks new grants.
- Reset during a pending response: rst asserted in T+1 suppresses rsp_valid in T+1 and the response is discarded. The memory write issued in T is not undone.
- A channel with req_valid dropped before grant is simply skipped. No stale grants.

## Configuration
- DMARB_LOCK_EN defined:
  - Adds the req_lock port.
  - A granted request with req_lock = 1 sets locked_ch to that channel.
  - While locked, only locked_ch can be granted; other channels see req_ready = 0 even if valid.
  - rr_ptr is frozen while locked.
  - The lock releases on the first granted request from locked_ch with req_lock = 0. rr_ptr then advances normally past it.
  - The locked channel idling (req_valid = 0) keeps the lock; mem_en = 0 in those cycles.
  - Reset clears the lock.
  - Intended use: atomic read-modify-write.
- DMARB_LOCK_EN undefined: no req_lock port and pure round-robin.

## Test plan
- Reset: hold rst = 1 for 2 cycles with all req_valid = 1 → req_ready = 0, rsp_valid = 0, mem_en = 0. After release, the first grant goes to ch0.
- Round-robin: NUM_CH = 4, all channels request loads continuously with mem_rdata = addr → grants ch0, ch1, ch2, ch3, ch0. Each rsp_valid arrives 1 cycle after its grant with the matching rdata.
- Store then load, same channel:
  - ch2 stores 0xDEADBEEF to address 0x40; rsp_valid[2] pulses with rsp_rdata = 0.
  - ch2 then loads 0x40 → rsp_rdata = 0xDEADBEEF.
- Pointer wrap and sparse requests:
  - Only ch3 and ch1 valid, rr_ptr = 2 → ch3 is granted first, then ch1.
  - Afterwards rr_ptr = 2.
- Reset mid-operation: ch1 load granted in T, rst = 1 in T+1 → rsp_valid = 0 in T+1 and rr_ptr = 0 after reset.
- Lock (DMARB_LOCK_EN):
  - ch0 issues a load with lock = 1, then idles 2 cycles, then a store with lock = 0, while ch1 is valid throughout.
  - ch1 sees no grant until the cycle after ch0's unlocking store.
